// File: rtl/demux_scheduler.sv
// demux_scheduler: steers a serial bit stream onto one of eight sink channels.
// Channels are granted for BURST beats at a time, either round-robin over the
// ready sinks or to a fixed channel, with strobed one-hot output lanes.
module demux_scheduler #(
    parameter int unsigned BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       k,
    input  logic       k_valid,
    output logic       k_ready,
    input  logic       mode,
    input  logic [2:0] s_fix,
    input  logic [7:0] ch_ready,
    output logic [2:0] s,
    output logic [7:0] y,
    output logic [7:0] y_valid,
    output logic       busy
);

    localparam int unsigned CH_N  = 8;
    localparam int unsigned CH_W  = 3;
    localparam int unsigned CNT_W = $clog2(BURST) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CH_W-1:0]  s_q, s_d;
    logic [CH_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_N-1:0]  y_q, y_d;
    logic [CH_N-1:0]  yv_q, yv_d;

    logic             rr_found;
    logic [CH_W-1:0]  rr_pick;
    logic [CH_W-1:0]  rr_cand;
    logic             xfer;
    logic             last_beat;

    // Source handshake is only open while granted, and then follows the sink.
    assign k_ready   = (state_q == GRANT) && ch_ready[s_q];
    assign xfer      = k_valid && k_ready;
    assign last_beat = (cnt_q == CNT_W'(BURST - 1));

    assign s       = s_q;
    assign y       = y_q;
    assign y_valid = yv_q;
    assign busy    = (state_q != IDLE);

    // Round-robin search: first ready channel after ptr, wrapping 7 -> 0.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = ptr_q;
        rr_cand  = ptr_q;
        for (int i = 1; i <= int'(CH_N); i++) begin
            rr_cand = CH_W'(ptr_q + CH_W'(i));
            if (!rr_found && ch_ready[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    // Next-state, grant bookkeeping and output lane computation.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        y_d     = '0;
        yv_d    = '0;

        unique case (state_q)
            IDLE: begin
                if (k_valid) begin
                    state_d = ARB;
                end
            end

            ARB: begin
                if (mode) begin
                    s_d     = s_fix;
                    cnt_d   = '0;
                    state_d = GRANT;
                end else if (rr_found) begin
                    s_d     = rr_pick;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end

            GRANT: begin
                if (xfer) begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    y_d   = CH_N'(k) << s_q;
                    yv_d  = CH_N'(1) << s_q;
                    if (last_beat) begin
                        ptr_d   = s_q;
                        cnt_d   = '0;
                        state_d = k_valid ? ARB : IDLE;
                    end
                end else if (!k_valid) begin
                    // Source went away mid-burst: give up the grant.
                    ptr_d   = s_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset leaves ptr at 7 so the first search starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            ptr_q   <= CH_W'(CH_N - 1);
            cnt_q   <= '0;
            y_q     <= '0;
            yv_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
        end
    end

endmodule

// File: tb/tb_demux_scheduler.sv
// Directed bench for demux_scheduler: BURST=4 and BURST=1 instances.
`timescale 1ns/1ps
module tb_demux_scheduler;

    logic       clk;
    logic       rst4, rst1;
    logic       k, k_valid, mode;
    logic [2:0] s_fix;
    logic [7:0] ch_ready;

    logic       kr4, busy4, kr1, busy1;
    logic [2:0] s4, s1;
    logic [7:0] y4, yv4, y1, yv1;

    int checks   = 0;
    int failures = 0;

    demux_scheduler #(.BURST(4)) u_dut4 (
        .clk(clk), .rst(rst4), .k(k), .k_valid(k_valid), .k_ready(kr4),
        .mode(mode), .s_fix(s_fix), .ch_ready(ch_ready),
        .s(s4), .y(y4), .y_valid(yv4), .busy(busy4)
    );

    demux_scheduler #(.BURST(1)) u_dut1 (
        .clk(clk), .rst(rst1), .k(k), .k_valid(k_valid), .k_ready(kr1),
        .mode(mode), .s_fix(s_fix), .ch_ready(ch_ready),
        .s(s1), .y(y1), .y_valid(yv1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] onehot;
        rst4 = 1'b0; rst1 = 1'b0;
        k = 1'b0; k_valid = 1'b0; mode = 1'b0; s_fix = 3'd0; ch_ready = 8'h00;
        #1 rst4 = 1'b1; rst1 = 1'b1;
        tick();
        check("rst_s",     32'(s4),    32'd0);
        check("rst_y",     32'(y4),    32'h00);
        check("rst_yv",    32'(yv4),   32'h00);
        check("rst_busy",  32'(busy4), 32'd0);
        check("rst_kready",32'(kr4),   32'd0);
        check("rst1_busy", 32'(busy1), 32'd0);

        // Fixed mode, channel 4, four beats.
        rst4 = 1'b0;
        mode = 1'b1; s_fix = 3'd4; ch_ready = 8'hFF; k = 1'b1; k_valid = 1'b1;
        check("idle_kready", 32'(kr4), 32'd0);
        tick();
        check("arb_busy",   32'(busy4), 32'd1);
        check("arb_kready", 32'(kr4),   32'd0);
        tick();
        check("fix_s",      32'(s4),  32'd4);
        check("fix_kready", 32'(kr4), 32'd1);
        tick();
        check("fix_yv1", 32'(yv4), 32'h10);
        check("fix_y1",  32'(y4),  32'h10);
        s_fix = 3'd5;
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("fix_yv%0d", i), 32'(yv4), 32'h10);
            check($sformatf("fix_s_hold%0d", i), 32'(s4), 32'd4);
        end
        check("fix_end_arb_kready", 32'(kr4),   32'd0);
        check("fix_end_arb_busy",   32'(busy4), 32'd1);
        tick();
        check("fix_resample_s", 32'(s4),  32'd5);
        check("fix_arb_yv",     32'(yv4), 32'h00);
        tick();
        check("s5_yv", 32'(yv4), 32'h20);

        // Asynchronous reset mid-burst, no clock edge.
        #1 rst4 = 1'b1;
        #1;
        check("arst_y",      32'(y4),    32'h00);
        check("arst_yv",     32'(yv4),   32'h00);
        check("arst_s",      32'(s4),    32'd0);
        check("arst_busy",   32'(busy4), 32'd0);
        check("arst_kready", 32'(kr4),   32'd0);
        k_valid = 1'b0;
        #1 rst4 = 1'b0;
        tick();
        check("post_rst_yv",   32'(yv4),   32'h00);
        check("post_rst_busy", 32'(busy4), 32'd0);

        // Round-robin: first search from channel 0, then skip to 6, 7, wrap to 0.
        mode = 1'b0; ch_ready = 8'hFF; k = 1'b1; k_valid = 1'b1;
        tick();
        tick();
        check("rr_first_s", 32'(s4), 32'd0);
        ch_ready = 8'b1100_0001;
        repeat (4) tick();
        check("rr_ch0_yv", 32'(yv4), 32'h01);
        tick();
        check("skip_s6", 32'(s4), 32'd6);
        repeat (4) tick();
        check("skip_ch6_yv", 32'(yv4), 32'h40);
        tick();
        check("skip_s7", 32'(s4), 32'd7);
        repeat (4) tick();
        tick();
        check("skip_wrap_s0", 32'(s4), 32'd0);

        // Early end on fresh grant, then stall on channel 7.
        k_valid = 1'b0;
        tick();
        check("early_idle_busy", 32'(busy4), 32'd0);
        check("early_idle_yv",   32'(yv4),   32'h00);
        ch_ready = 8'h80; k_valid = 1'b1;
        tick();
        tick();
        check("stall_s7", 32'(s4), 32'd7);
        k = 1'b1;
        tick();
        check("stall_b1_yv", 32'(yv4), 32'h80);
        check("stall_b1_y",  32'(y4),  32'h80);
        ch_ready = 8'h00; k = 1'b0;
        #1 check("stall_kready0", 32'(kr4), 32'd0);
        tick();
        check("stall_yv0", 32'(yv4), 32'h00);
        k = 1'b1;
        #1 check("stall_kready1", 32'(kr4), 32'd0);
        tick();
        check("stall_yv1", 32'(yv4), 32'h00);
        k = 1'b0;
        tick();
        check("stall_yv2",  32'(yv4),   32'h00);
        check("stall_s",    32'(s4),    32'd7);
        check("stall_busy", 32'(busy4), 32'd1);
        ch_ready = 8'h80; k = 1'b0;
        #1 check("resume_kready", 32'(kr4), 32'd1);
        tick();
        check("resume_b2_yv", 32'(yv4), 32'h80);
        check("resume_b2_y",  32'(y4),  32'h00);
        k = 1'b1;
        tick();
        check("resume_b3_y",      32'(y4),  32'h80);
        check("resume_b3_kready", 32'(kr4), 32'd1);
        tick();
        check("resume_b4_yv",  32'(yv4),   32'h80);
        check("resume_b4_y",   32'(y4),    32'h80);
        check("burst_end_kready", 32'(kr4), 32'd0);
        check("burst_end_busy",   32'(busy4), 32'd1);

        // Starvation: nothing ready keeps the scheduler in arbitration.
        ch_ready = 8'h00;
        repeat (3) tick();
        check("starve_busy",   32'(busy4), 32'd1);
        check("starve_kready", 32'(kr4),   32'd0);
        check("starve_s",      32'(s4),    32'd7);
        check("starve_yv",     32'(yv4),   32'h00);
        ch_ready = 8'hFF;
        tick();
        check("unstarve_s", 32'(s4), 32'd0);
        tick();
        tick();
        check("two_beats_yv", 32'(yv4), 32'h01);
        k_valid = 1'b0;
        tick();
        check("drop_idle_busy", 32'(busy4), 32'd0);
        check("drop_idle_yv",   32'(yv4),   32'h00);
        k_valid = 1'b1;
        tick();
        tick();
        check("drop_ptr_next_s", 32'(s4), 32'd1);

        // BURST=1: grant walks 0..7 and wraps, one beat each.
        rst4 = 1'b1;
        mode = 1'b0; ch_ready = 8'hFF; k = 1'b1; k_valid = 1'b1;
        rst1 = 1'b0;
        tick();
        tick();
        for (int i = 0; i <= 8; i++) begin
            onehot = 8'h01 << (i % 8);
            check($sformatf("b1_s%0d", i),      32'(s1),  32'(i % 8));
            check($sformatf("b1_kready%0d", i), 32'(kr1), 32'd1);
            tick();
            check($sformatf("b1_yv%0d", i), 32'(yv1), 32'(onehot));
            check($sformatf("b1_y%0d", i),  32'(y1),  32'(onehot));
            tick();
            check($sformatf("b1_arb_yv%0d", i), 32'(yv1), 32'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_scheduler.md
DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

Interface
REQ-001 Parameter: BURST, default 4, number of accepted beats per grant before re-arbitration (legal 1..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 k  input  1  data bit to be steered.
REQ-005 k_valid  input  1  source has a data bit on k.
REQ-006 k_ready  output  1  scheduler accepts k this cycle; transfer = k_valid & k_ready.
REQ-007 mode  input  1  0 = round-robin over ready channels, 1 = fixed channel s_fix.
REQ-008 s_fix  input  3  channel index used when mode=1.
REQ-009 ch_ready  input  8  per-channel sink ready, bit i = channel i.
REQ-010 s  output  3  currently granted channel index (registered).
REQ-011 y  output  8  steered data; y[s] carries the accepted bit, all other bits 0.
REQ-012 y_valid  output  8  one-hot strobe marking the channel written this cycle; all zero when no write.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ARB, GRANT; encoding left to implementer.
REQ-015 IDLE: k_ready=0; k_valid=1 -> ARB next cycle; else stay.
REQ-016 ARB, mode=1: load s<=s_fix, beat count<=0, -> GRANT, regardless of ch_ready.
REQ-017 ARB, mode=0: search channels ptr+1, ptr+2, ... cyclically (7 wraps to 0); first with ch_ready=1 is loaded into s, beat count<=0, -> GRANT.
REQ-018 ARB, mode=0, ch_ready=8'h00: stay in ARB, s unchanged, re-search next cycle.
REQ-019 ARB: k_ready=0; mode and s_fix SHALL be sampled only in ARB; changes during GRANT are ignored.
REQ-020 GRANT: k_ready SHALL equal ch_ready[s] combinationally; no other term.
REQ-021 GRANT transfer: beat count increments; next cycle y[s]<=k, y_valid<=(1<<s), other bits 0 (latency 1 cycle).
REQ-022 GRANT, no transfer in a cycle: y and y_valid SHALL be 8'h00 next cycle.
REQ-023 GRANT, transfer with beat count = BURST-1: ptr<=s, -> ARB if k_valid stays high, else -> IDLE (state update on that edge; k_valid sampled same edge).
REQ-024 GRANT, k_valid=0 before burst complete: ptr<=s, -> IDLE, beat count discarded.
REQ-025 GRANT, ch_ready[s]=0 with k_valid=1: stall in GRANT, beat count held, no strobe.
REQ-026 BURST=1: every transfer ends the grant; round-robin advances one channel per beat.
REQ-027 Beat count width SHALL be ceil(log2(BURST))+1 bits minimum; no overflow for BURST<=16.
REQ-028 Round-robin fairness: with all ch_ready=1 and continuous k_valid, grants SHALL visit channels 0..7 in order, each for BURST beats.

Reset
REQ-029 rst=1 SHALL immediately (no clock edge) force: state=IDLE, s=3'd0, ptr=3'd7, beat count=0, y=8'h00, y_valid=8'h00, busy=0, k_ready=0.
REQ-030 rst asserted mid-burst SHALL drop the burst; no strobe after rst release until a new ARB/GRANT cycle.
REQ-031 First mode=0 arbitration after reset SHALL start searching at channel 0.

Verification
REQ-032 Reset: rst=1 while GRANT on s=5 -> same timestep y=0, y_valid=0, s=0, busy=0, k_ready=0.
REQ-033 Fixed mode: mode=1, s_fix=3'b100, ch_ready=8'hFF, k_valid=1, k=1 for 4 beats (BURST=4) -> y_valid=8'h10, y=8'h10 on 4 consecutive cycles, then ARB.
REQ-034 Round-robin: mode=0, ch_ready=8'hFF, continuous k_valid, BURST=1 -> s sequence 0,1,2,...,7,0; y_valid walks 8'h01..8'h80.
REQ-035 Skip: mode=0, ch_ready=8'b1100_0001, ptr=0 -> next grant s=6, then 7, then 0 (wrap).
REQ-036 Stall: GRANT s=7, ch_ready[7] dropped 3 cycles mid-burst with k=0/1 pattern -> k_ready=0, y_valid=0 for 3 cycles, beat count held, remaining beats delivered after ch_ready[7]=1.
REQ-037 Starvation/early end: mode=0, ch_ready=8'h00 -> stays ARB, busy=1, k_ready=0; k_valid drop after 2 of 4 beats -> IDLE, ptr=granted channel.
